// File: rtl/led_status_scheduler.sv
// Round-robin blink-code scheduler: plays one requester's blink count on the LED,
// followed by an off gap, and shows the heartbeat when nothing is queued.
module led_status_scheduler #(
    parameter int N_REQ     = 4,
    parameter int GAP_TICKS = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tick,
    input  logic                 beat,
    input  logic [N_REQ-1:0]     req,
    input  logic [3*N_REQ-1:0]   code,
    output logic                 led,
    output logic                 busy,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     done
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t             state, state_next;
    logic [3:0]         remaining, remaining_next;
    logic [7:0]         gap_cnt, gap_cnt_next;
    logic [IDX_W-1:0]   last_winner, last_winner_next;
    logic               led_next, busy_next;
    logic [N_REQ-1:0]   grant_next, done_next;

    logic               found;
    logic [IDX_W-1:0]   winner;
    logic [2:0]         winner_code;
    logic               gap_last;

    // A code field of zero stands for eight blinks.
    function automatic logic [3:0] decode_blinks(input logic [2:0] c);
        return (c == 3'd0) ? 4'd8 : {1'b0, c};
    endfunction

    // Round-robin search starting just after the previous winner.
    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_winner) + k) % N_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

    assign winner_code = code[3*int'(winner) +: 3];
    assign gap_last    = (gap_cnt == 8'(GAP_TICKS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            remaining   <= '0;
            gap_cnt     <= '0;
            last_winner <= IDX_W'(N_REQ - 1);
            led         <= 1'b0;
            busy        <= 1'b0;
            grant       <= '0;
            done        <= '0;
        end else begin
            state       <= state_next;
            remaining   <= remaining_next;
            gap_cnt     <= gap_cnt_next;
            last_winner <= last_winner_next;
            led         <= led_next;
            busy        <= busy_next;
            grant       <= grant_next;
            done        <= done_next;
        end
    end

    always_comb begin
        state_next       = state;
        remaining_next   = remaining;
        gap_cnt_next     = gap_cnt;
        last_winner_next = last_winner;
        unique case (state)
            IDLE: begin
                // Grant does not wait for tick; any tick on this edge is dropped.
                if (found) begin
                    state_next       = ON;
                    remaining_next   = decode_blinks(winner_code);
                    last_winner_next = winner;
                end
            end
            ON: begin
                if (tick) begin
                    remaining_next = remaining - 4'd1;
                    state_next     = OFF;
                end
            end
            OFF: begin
                if (tick) begin
                    if (remaining == 4'd0) begin
                        state_next   = GAP;
                        gap_cnt_next = '0;
                    end else begin
                        state_next = ON;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (gap_last) begin
                        state_next = IDLE;
                    end else begin
                        gap_cnt_next = gap_cnt + 8'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        led_next   = led;
        grant_next = grant;
        done_next  = '0;
        busy_next  = (state_next != IDLE);
        unique case (state)
            IDLE: begin
                if (found) begin
                    led_next   = 1'b1;
                    grant_next = N_REQ'(1) << winner;
                end else begin
                    led_next   = beat;
                    grant_next = '0;
                end
            end
            ON: begin
                if (tick) led_next = 1'b0;
            end
            OFF: begin
                if (tick && remaining != 4'd0) led_next = 1'b1;
            end
            GAP: begin
                led_next = 1'b0;
                if (tick && gap_last) begin
                    done_next  = grant;
                    grant_next = '0;
                end
            end
            default: begin
                led_next   = 1'b0;
                grant_next = '0;
            end
        endcase
    end

endmodule
